ext_mem_responder: RTL and testbench

EXT_MEM_RESPONDER -- requirements
Module: ext_mem_responder

---
 rtl/ext_mem_pkg.sv | 17 +
 rtl/ext_mem_responder_if.sv | 22 ++
 rtl/ext_mem_sram_array.sv | 33 +++
 rtl/ext_mem_responder.sv | 149 ++++++++++++++
 tb/tb_ext_mem_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and constants for the external memory responder.
package ext_mem_pkg;

   localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
   localparam int unsigned DEFAULT_WAIT_STATES = 2;
   localparam int unsigned WAIT_CNT_W          = 4;
   localparam logic [7:0]  ERR_CNT_MAX         = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WAIT = 3'd1,
      ST_ACK  = 3'd2,
      ST_ERR  = 3'd3,
      ST_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/ext_mem_responder_if.sv
// Wishbone classic bus between an initiator (master) and the memory responder (slave).
interface ext_mem_responder_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_ack_o;
   logic        wb_err_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o, wb_err_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o, wb_err_o
   );
endinterface

// File: rtl/ext_mem_sram_array.sv
// Single-port synchronous RAM with byte write enables; only the read register is reset.
module ext_mem_sram_array #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          re,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-masked write; storage keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   // Read register updates only on a read, so it holds between reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= 32'd0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/ext_mem_responder.sv
// Wishbone classic memory responder with programmable wait states and error/access statistics.
module ext_mem_responder
   import ext_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
   parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES
) (
   input  logic                 clk,
   input  logic                 rst,
   ext_mem_responder_if.slave   wb,
   output logic                 busy,
   output logic [15:0]          access_count,
   output logic [7:0]           err_count
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
      (WAIT_STATES == 0) ? WAIT_CNT_W'(0) : WAIT_CNT_W'(WAIT_STATES - 1);

   state_e                state_q, state_d;
   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic                  latch_c;
   logic                  req_c;
   logic                  bad_c;

   logic [AW-1:0]         adr_q;
   logic [31:0]           dat_q;
   logic                  we_q;
   logic [3:0]            sel_q;
   logic                  ack_q;
   logic                  err_q;

   logic                  ram_re_c;
   logic                  ram_we_c;
   logic [AW-1:0]         ram_addr_c;

   assign req_c = wb.wb_cyc_i & wb.wb_stb_i;
   assign bad_c = (wb.wb_adr_i[1:0] != 2'b00) ||
                  ({2'b00, wb.wb_adr_i[31:2]} >= 32'(DEPTH_WORDS));

   // State and wait-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // Next-state logic: accept, wait out the latency, terminate, then a one-cycle guard.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      latch_c    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_c) begin
               latch_c = 1'b1;
               if (bad_c) begin
                  state_d = ST_ERR;
               end else if (WAIT_STATES > 0) begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = WAIT_LOAD;
               end else begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_WAIT: begin
            if (!wb.wb_cyc_i) begin
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == '0) begin
               state_d = ST_ACK;
            end else begin
               wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
            end
         end
         ST_ACK:  state_d = ST_DONE;
         ST_ERR:  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture the request so later input changes cannot affect it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adr_q <= '0;
         dat_q <= 32'd0;
         we_q  <= 1'b0;
         sel_q <= 4'd0;
      end else if (latch_c) begin
         adr_q <= wb.wb_adr_i[AW+1:2];
         dat_q <= wb.wb_dat_i;
         we_q  <= wb.wb_we_i;
         sel_q <= wb.wb_sel_i;
      end
   end

   // Registered termination and busy flags, mirroring the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         busy  <= 1'b0;
      end else begin
         ack_q <= (state_d == ST_ACK);
         err_q <= (state_d == ST_ERR);
         busy  <= (state_d != ST_IDLE);
      end
   end

   // Statistics: one access per ACK (wrapping), one error per ERR (saturating).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         access_count <= 16'd0;
         err_count    <= 8'd0;
      end else begin
         if (state_q == ST_ACK) access_count <= access_count + 16'd1;
         if ((state_q == ST_ERR) && (err_count != ERR_CNT_MAX)) err_count <= err_count + 8'd1;
      end
   end

   // RAM read fires on the edge entering ACK; a zero-wait read uses the live address.
   assign ram_addr_c = (state_q == ST_IDLE) ? wb.wb_adr_i[AW+1:2] : adr_q;
   assign ram_re_c   = (state_d == ST_ACK) &&
                       !((state_q == ST_IDLE) ? wb.wb_we_i : we_q);
   assign ram_we_c   = (state_q == ST_ACK) && we_q;

   ext_mem_sram_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_sram (
      .clk   (clk),
      .rst   (rst),
      .re    (ram_re_c),
      .we    (ram_we_c),
      .be    (sel_q),
      .addr  (ram_addr_c),
      .wdata (dat_q),
      .rdata (wb.wb_dat_o)
   );

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_err_o = err_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// Scoreboard bench for ext_mem_responder: a 2-wait-state build and a zero-wait build.
module tb_ext_mem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int          WS2   = 2;
   localparam int          WS0   = 0;

   typedef struct {
      bit          is_err;
      bit          chk_data;
      logic [31:0] data;
      int          exp_edge;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy2, busy0;
   logic [15:0] acc2, acc0;
   logic [7:0]  errc2, errc0;

   int   checks   = 0;
   int   failures = 0;
   int   cyc_cnt  = 0;
   int   ack0_cnt = 0;
   exp_t q2[$];
   exp_t q0[$];
   exp_t m2, m0;

   ext_mem_responder_if wb2();
   ext_mem_responder_if wb0();

   ext_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS2)) dut2 (
      .clk(clk), .rst(rst), .wb(wb2.slave),
      .busy(busy2), .access_count(acc2), .err_count(errc2));

   ext_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) dut0 (
      .clk(clk), .rst(rst), .wb(wb0.slave),
      .busy(busy0), .access_count(acc0), .err_count(errc0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit w, input bit cyc, input bit stb, input bit we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      if (w) begin
         wb0.wb_cyc_i = cyc; wb0.wb_stb_i = stb; wb0.wb_we_i = we;
         wb0.wb_adr_i = adr; wb0.wb_dat_i = dat; wb0.wb_sel_i = sel;
      end else begin
         wb2.wb_cyc_i = cyc; wb2.wb_stb_i = stb; wb2.wb_we_i = we;
         wb2.wb_adr_i = adr; wb2.wb_dat_i = dat; wb2.wb_sel_i = sel;
      end
   endtask

   function automatic bit term(input bit w);
      return w ? (wb0.wb_ack_o | wb0.wb_err_o) : (wb2.wb_ack_o | wb2.wb_err_o);
   endfunction

   // Issue one strobe, push its expected termination, scramble inputs once accepted.
   task automatic xact(input bit w, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit exp_err, input logic [31:0] exp_data,
                       input int hold);
      exp_t e;
      bit   seen;
      int   ws;
      ws = w ? WS0 : WS2;
      @(negedge clk);
      e.is_err   = exp_err;
      e.chk_data = !we && !exp_err;
      e.data     = exp_data;
      e.exp_edge = cyc_cnt + 1 + (exp_err ? 0 : ws);
      if (w) q0.push_back(e); else q2.push_back(e);
      drive(w, 1'b1, 1'b1, we, adr, dat, sel);
      @(negedge clk);
      seen = term(w);
      drive(w, 1'b1, 1'b1, ~we, ~adr, ~dat, ~sel);
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = term(w);
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL xact_timeout: no termination for addr %h within 40 cycles", adr);
      end
      repeat (hold) @(negedge clk);
      drive(w, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (3) @(negedge clk);
   endtask

   // Monitor for the 2-wait build: every termination must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && (wb2.wb_ack_o || wb2.wb_err_o)) begin
         check("dut2_ack_and_err", 32'(wb2.wb_ack_o & wb2.wb_err_o), 32'd0);
         if (q2.size() == 0) begin
            checks++; failures++;
            $display("FAIL dut2_unexpected_term: ack=%b err=%b with nothing outstanding",
                     wb2.wb_ack_o, wb2.wb_err_o);
         end else begin
            m2 = q2.pop_front();
            check("dut2_term_kind", 32'(wb2.wb_err_o), 32'(m2.is_err));
            check("dut2_term_edge", 32'(cyc_cnt), 32'(m2.exp_edge));
            if (m2.chk_data) check("dut2_rdata", wb2.wb_dat_o, m2.data);
         end
      end
   end

   // Monitor for the zero-wait build.
   always @(negedge clk) begin
      if (!rst && (wb0.wb_ack_o || wb0.wb_err_o)) begin
         if (wb0.wb_ack_o) ack0_cnt++;
         check("dut0_ack_and_err", 32'(wb0.wb_ack_o & wb0.wb_err_o), 32'd0);
         if (q0.size() == 0) begin
            checks++; failures++;
            $display("FAIL dut0_unexpected_term: ack=%b err=%b with nothing outstanding",
                     wb0.wb_ack_o, wb0.wb_err_o);
         end else begin
            m0 = q0.pop_front();
            check("dut0_term_kind", 32'(wb0.wb_err_o), 32'(m0.is_err));
            check("dut0_term_edge", 32'(cyc_cnt), 32'(m0.exp_edge));
            if (m0.chk_data) check("dut0_rdata", wb0.wb_dat_o, m0.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state of both builds
      check("rst_dat2",  wb2.wb_dat_o, 32'd0);
      check("rst_ack2",  32'(wb2.wb_ack_o), 32'd0);
      check("rst_err2",  32'(wb2.wb_err_o), 32'd0);
      check("rst_busy2", 32'(busy2), 32'd0);
      check("rst_acc2",  32'(acc2), 32'd0);
      check("rst_errc2", 32'(errc2), 32'd0);
      check("rst_dat0",  wb0.wb_dat_o, 32'd0);
      check("rst_busy0", 32'(busy0), 32'd0);

      // Full write then read back
      xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0, 0);
      xact(1'b0, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0, 32'hDEADBEEF, 0);
      check("acc_after_two", 32'(acc2), 32'd2);
      check("rdata_hold", wb2.wb_dat_o, 32'hDEADBEEF);

      // Single-byte write, then an all-disabled write that must change nothing
      xact(1'b0, 1'b1, 32'h10, 32'h0000AB00, 4'b0010, 1'b0, 32'd0, 0);
      xact(1'b0, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0, 32'hDEADABEF, 0);
      xact(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'd0, 0);
      xact(1'b0, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0, 32'hDEADABEF, 0);
      check("acc_after_six", 32'(acc2), 32'd6);

      // Out-of-range and misaligned requests
      xact(1'b0, 1'b0, 32'h1000, 32'd0, 4'hF, 1'b1, 32'd0, 0);
      xact(1'b0, 1'b0, 32'h12, 32'd0, 4'hF, 1'b1, 32'd0, 0);
      check("errc_two", 32'(errc2), 32'd2);
      check("acc_no_err_inc", 32'(acc2), 32'd6);
      xact(1'b0, 1'b1, 32'h13, 32'h0, 4'hF, 1'b1, 32'd0, 0);
      xact(1'b0, 1'b1, 32'h1010, 32'h0, 4'hF, 1'b1, 32'd0, 0);
      check("errc_four", 32'(errc2), 32'd4);
      xact(1'b0, 1'b0, 32'h10, 32'd0, 4'hF, 1'b0, 32'hDEADABEF, 0);

      // Abort a write by dropping cyc during WAIT
      xact(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 32'd0, 0);
      check("acc_before_abort", 32'(acc2), 32'd8);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF);
      @(negedge clk);
      check("abort_busy", 32'(busy2), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (4) @(negedge clk);
      check("abort_idle", 32'(busy2), 32'd0);
      check("abort_acc", 32'(acc2), 32'd8);
      xact(1'b0, 1'b0, 32'h20, 32'd0, 4'hF, 1'b0, 32'hCAFEF00D, 0);

      // Reset during WAIT of a write
      xact(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 1'b0, 32'd0, 0);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h30, 32'h55555555, 4'hF);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_ack",  32'(wb2.wb_ack_o), 32'd0);
      check("midrst_err",  32'(wb2.wb_err_o), 32'd0);
      check("midrst_busy", 32'(busy2), 32'd0);
      check("midrst_dat",  wb2.wb_dat_o, 32'd0);
      check("midrst_acc",  32'(acc2), 32'd0);
      check("midrst_errc", 32'(errc2), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      xact(1'b0, 1'b0, 32'h30, 32'd0, 4'hF, 1'b0, 32'hA5A5A5A5, 0);
      check("post_rst_acc", 32'(acc2), 32'd1);

      // Zero-wait build with stb held through ACK and DONE
      xact(1'b1, 1'b1, 32'h0, 32'h01020304, 4'hF, 1'b0, 32'd0, 2);
      xact(1'b1, 1'b0, 32'h0, 32'd0, 4'hF, 1'b0, 32'h01020304, 2);
      xact(1'b1, 1'b0, 32'h2, 32'd0, 4'hF, 1'b1, 32'd0, 2);
      check("dut0_ack_count", 32'(ack0_cnt), 32'd2);
      check("dut0_acc", 32'(acc0), 32'd2);
      check("dut0_errc", 32'(errc0), 32'd1);

      check("q2_drained", 32'(q2.size()), 32'd0);
      check("q0_drained", 32'(q0.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
